emc_slave: RTL and testbench



---
 rtl/emc_pkg.sv | 23 ++
 rtl/emc_if.sv | 34 +++
 rtl/emc_sync.sv | 43 ++++
 rtl/emc_slave.sv | 200 ++++++++++++++++++++
 tb/tb_emc_slave.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/emc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : emc_pkg
// Description : Shared types and constants for the EMC static-memory target.
//               Holds the bus state encoding, the synchroniser depth, the data
//               returned on a read timeout and the EMC data width.
// Revision    : 1.0 - initial release
// ============================================================================
package emc_pkg;

    localparam int              EMC_SYNC_STAGES     = 3;
    localparam int              EMC_DW              = 16;
    localparam logic [EMC_DW-1:0] EMC_RD_TIMEOUT_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD      = 2'd2,
        ST_RD_HOLD = 2'd3
    } emc_state_t;

endpackage
`default_nettype wire

// File: rtl/emc_if.sv
`default_nettype none
// ============================================================================
// Module      : emc_if
// Description : Wishbone-style classic-cycle register bus between the EMC
//               target (master modport) and the register file (slave modport).
//               adr_o word address, dat_o write data, sel_o byte enables,
//               we_o write, cyc_o/stb_o cycle strobe, err_o error pulse,
//               dat_i read data, ack_i acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
interface emc_if #(
    parameter int AW = 8
);
    logic [AW-2:0] adr_o;
    logic [15:0]   dat_o;
    logic [1:0]    sel_o;
    logic          we_o;
    logic          cyc_o;
    logic          stb_o;
    logic          err_o;
    logic [15:0]   dat_i;
    logic          ack_i;

    modport master (
        output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, err_o,
        input  dat_i, ack_i
    );

    modport slave (
        input  adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, err_o,
        output dat_i, ack_i
    );
endinterface
`default_nettype wire

// File: rtl/emc_sync.sv
`default_nettype none
// ============================================================================
// Module      : emc_sync
// Description : Multi-stage input pipeline bringing asynchronous EMC pins into
//               the clk_i domain. The last two stages are exported so that
//               edges can be detected between them.
//               clk_i/rst_i clock and sync reset, i_rst_val value loaded on
//               reset, i_d raw pins, o_s2/o_s3 second and third stages.
// Revision    : 1.0 - initial release
// ============================================================================
module emc_sync
    import emc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] i_rst_val,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_s2,
    output logic [WIDTH-1:0] o_s3
);

    logic [WIDTH-1:0] r_pipe [EMC_SYNC_STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < EMC_SYNC_STAGES; i++) begin
                r_pipe[i] <= i_rst_val;
            end
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < EMC_SYNC_STAGES; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_s2 = r_pipe[EMC_SYNC_STAGES-2];
    assign o_s3 = r_pipe[EMC_SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/emc_slave.sv
`default_nettype none
// ============================================================================
// Module      : emc_slave
// Description : LPC43xx EMC static-memory target, 16-bit port. Synchronises
//               the EMC pins and turns each WEN pulse / OEN access into one
//               classic bus cycle on the register bus.
//               clk_i/rst_i clock and sync reset; A/D/BLSN/CSN/WEN/OEN EMC
//               pins (D bidirectional); bus = register-bus master side.
// Revision    : 1.0 - initial release
// ============================================================================
module emc_slave
    import emc_pkg::*;
#(
    parameter int AW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [AW-1:0]     A,
    inout  wire  [EMC_DW-1:0] D,
    input  logic [3:0]        BLSN,
    input  logic              CSN,
    input  logic              WEN,
    input  logic              OEN,
    emc_if.master             bus
);

    localparam int                c_PIPE_W   = 5 + AW + EMC_DW;
    localparam logic [c_PIPE_W-1:0] c_PIPE_RST = {3'b111, {(c_PIPE_W-3){1'b0}}};
    localparam logic [3:0]        c_TIMEOUT  = 4'(TIMEOUT);

    logic [c_PIPE_W-1:0] w_s2;
    logic [c_PIPE_W-1:0] w_s3;

    emc_sync #(.WIDTH(c_PIPE_W)) u_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_rst_val (c_PIPE_RST),
        .i_d       ({CSN, WEN, OEN, BLSN[1:0], A, D}),
        .o_s2      (w_s2),
        .o_s3      (w_s3)
    );

    logic              w_s2_csn, w_s2_wen, w_s2_oen;
    logic              w_s3_csn, w_s3_wen, w_s3_oen;
    logic [1:0]        w_s3_blsn;
    logic [AW-1:0]     w_s3_a;
    logic [EMC_DW-1:0] w_s3_d;

    assign w_s2_csn  = w_s2[c_PIPE_W-1];
    assign w_s2_wen  = w_s2[c_PIPE_W-2];
    assign w_s2_oen  = w_s2[c_PIPE_W-3];
    assign w_s3_csn  = w_s3[c_PIPE_W-1];
    assign w_s3_wen  = w_s3[c_PIPE_W-2];
    assign w_s3_oen  = w_s3[c_PIPE_W-3];
    assign w_s3_blsn = w_s3[c_PIPE_W-4 -: 2];
    assign w_s3_a    = w_s3[EMC_DW +: AW];
    assign w_s3_d    = w_s3[EMC_DW-1:0];

    // Only the strobes of s2 matter; A[0] and the upper lanes are don't-care.
    logic w_unused;
    assign w_unused = ^{BLSN[3:2], w_s2, w_s3_a[0]};

    emc_state_t          r_state;
    logic [3:0]          r_cnt;
    logic                r_pend_vld;
    logic [AW-2:0]       r_pend_adr;
    logic [EMC_DW-1:0]   r_pend_dat;
    logic [1:0]          r_pend_sel;
    logic                r_rd_req;
    logic [EMC_DW-1:0]   r_rd_q;
    logic                r_rd_valid;
    logic [AW-2:0]       r_adr;
    logic [EMC_DW-1:0]   r_dat;
    logic [1:0]          r_sel;
    logic                r_we;
    logic                r_stb;
    logic                r_err;

    logic w_ill2, w_ill3, w_wr_ev, w_rd_ev, w_timeout, w_launch, w_overrun, w_to_err;

    assign w_ill2    = ~w_s2_csn & ~w_s2_wen & ~w_s2_oen;
    assign w_ill3    = ~w_s3_csn & ~w_s3_wen & ~w_s3_oen;
    // WEN rise; a WEN rise leaving the illegal all-low state is not a write.
    assign w_wr_ev   = ~w_s3_csn & ~w_s3_wen & w_s3_oen & w_s2_wen;
    // OEN fall, or CSN fall while OEN is already low.
    assign w_rd_ev   = ~w_s2_csn & ~w_s2_oen & w_s2_wen & (w_s3_oen | w_s3_csn);
    assign w_timeout = (r_cnt == c_TIMEOUT);
    // The buffer is freed as soon as IDLE copies it onto the bus registers,
    // so one further write can queue behind a stalled bus cycle.
    assign w_launch  = (r_state == ST_IDLE) & r_pend_vld;
    assign w_overrun = w_wr_ev & r_pend_vld & ~w_launch;
    assign w_to_err  = ((r_state == ST_WR) | (r_state == ST_RD)) & ~bus.ack_i & w_timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_pend_vld <= 1'b0;
            r_pend_adr <= '0;
            r_pend_dat <= '0;
            r_pend_sel <= 2'b00;
            r_rd_req   <= 1'b0;
            r_rd_q     <= '0;
            r_rd_valid <= 1'b0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_sel      <= 2'b00;
            r_we       <= 1'b0;
            r_stb      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_overrun | (w_ill2 & ~w_ill3) | w_to_err;

            if (w_wr_ev && (!r_pend_vld || w_launch)) begin
                r_pend_vld <= 1'b1;
                r_pend_adr <= w_s3_a[AW-1:1];
                r_pend_dat <= w_s3_d;
                r_pend_sel <= ~w_s3_blsn;
            end else if (w_launch) begin
                r_pend_vld <= 1'b0;
            end

            // A read request is dropped if the master abandons the access.
            if (w_rd_ev) begin
                r_rd_req <= 1'b1;
            end else if (w_s3_csn || w_s3_oen) begin
                r_rd_req <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_pend_vld) begin
                        r_state <= ST_WR;
                        r_adr   <= r_pend_adr;
                        r_dat   <= r_pend_dat;
                        r_sel   <= r_pend_sel;
                        r_we    <= 1'b1;
                        r_stb   <= 1'b1;
                        r_cnt   <= 4'd1;
                    end else if (r_rd_req) begin
                        r_state  <= ST_RD;
                        r_adr    <= w_s3_a[AW-1:1];
                        r_sel    <= 2'b11;
                        r_we     <= 1'b0;
                        r_stb    <= 1'b1;
                        r_cnt    <= 4'd1;
                        r_rd_req <= 1'b0;
                    end
                end
                // r_cnt holds the number of cycles spent in the state so far,
                // including the current one.
                ST_WR: begin
                    if (bus.ack_i || w_timeout) begin
                        r_state <= ST_IDLE;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_RD: begin
                    if (bus.ack_i) begin
                        r_rd_q     <= bus.dat_i;
                        r_rd_valid <= 1'b1;
                        r_stb      <= 1'b0;
                        r_state    <= ST_RD_HOLD;
                    end else if (w_timeout) begin
                        r_rd_q     <= EMC_RD_TIMEOUT_DATA;
                        r_rd_valid <= 1'b1;
                        r_stb      <= 1'b0;
                        r_state    <= ST_RD_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_RD_HOLD: begin
                    if (w_s3_oen || w_s3_csn) begin
                        r_rd_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Raw pins gate the driver so it turns off without synchroniser delay.
    assign D = (~CSN & ~OEN & WEN & r_rd_valid) ? r_rd_q : {EMC_DW{1'bz}};

    assign bus.adr_o = r_adr;
    assign bus.dat_o = r_dat;
    assign bus.sel_o = r_sel;
    assign bus.we_o  = r_we;
    assign bus.cyc_o = r_stb;
    assign bus.stb_o = r_stb;
    assign bus.err_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_emc_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_emc_slave
// Description : Directed self-checking bench for emc_slave. An EMC master
//               model drives the pins, a register-bus responder returns data
//               and acks, and a monitor logs every bus cycle and error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_emc_slave;
    import emc_pkg::*;

    localparam int AW      = 8;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] A        = '0;
    logic [3:0]    BLSN     = 4'hF;
    logic          CSN      = 1'b1;
    logic          WEN      = 1'b1;
    logic          OEN      = 1'b1;
    logic [15:0]   r_mst_d  = '0;
    logic          r_mst_oe = 1'b0;
    wire  [15:0]   D;
    assign D = r_mst_oe ? r_mst_d : 16'hzzzz;

    // Register-bus responder: 0 = ack tied high, 1 = ack one cycle late, 2 = never.
    int          ack_mode = 0;
    logic        r_ack_d  = 1'b0;
    logic [15:0] rd_data  = 16'hBEEF;

    emc_if #(.AW(AW)) bus ();

    always @(posedge clk) r_ack_d <= bus.stb_o & ~r_ack_d & (ack_mode == 1);
    assign bus.ack_i = (ack_mode == 0) | ((ack_mode == 1) & r_ack_d);
    assign bus.dat_i = rd_data;

    emc_slave #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .A     (A),
        .D     (D),
        .BLSN  (BLSN),
        .CSN   (CSN),
        .WEN   (WEN),
        .OEN   (OEN),
        .bus   (bus)
    );

    // ---------------- monitor ----------------
    typedef struct packed {
        logic [6:0]  adr;
        logic [15:0] dat;
        logic [1:0]  sel;
        logic        we;
    } cyc_t;

    cyc_t log_q[$];
    int   n_cyc = 0, n_err = 0, cur_len = 0, last_len = 0, n_cs_ne = 0;
    logic prev_stb = 1'b0;

    always @(negedge clk) begin
        if (bus.stb_o && !prev_stb) begin
            log_q.push_back('{adr: bus.adr_o, dat: bus.dat_o, sel: bus.sel_o, we: bus.we_o});
            n_cyc++;
        end
        if (bus.stb_o) begin
            cur_len++;
        end else if (prev_stb) begin
            last_len = cur_len;
            cur_len  = 0;
        end
        if (bus.err_o) n_err++;
        if (bus.cyc_o !== bus.stb_o) n_cs_ne++;
        prev_stb = bus.stb_o;
    end

    function automatic cyc_t get_cyc(input int i);
        if (i < log_q.size()) return log_q[i];
        return '1;
    endfunction

    task automatic mon_clr();
        @(posedge clk);
        log_q.delete();
        n_cyc    = 0;
        n_err    = 0;
        last_len = 0;
    endtask

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- EMC master model ----------------
    task automatic mst_idle();
        CSN      = 1'b1;
        WEN      = 1'b1;
        OEN      = 1'b1;
        BLSN     = 4'hF;
        r_mst_oe = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input int waitwen, input int waitwr);
        @(negedge clk);
        CSN = 1'b0; A = a; BLSN = 4'h0; r_mst_d = d; r_mst_oe = 1'b1;
        repeat (waitwen + 1) @(negedge clk);
        WEN = 1'b0;
        repeat (waitwr + 1) @(negedge clk);
        WEN = 1'b1;
        @(negedge clk);
        mst_idle();
    endtask

    task automatic wr2(input logic [7:0] a, input logic [31:0] d, input int waitwen, input int waitwr);
        @(negedge clk);
        CSN = 1'b0; A = a; BLSN = 4'h0; r_mst_d = d[15:0]; r_mst_oe = 1'b1;
        repeat (waitwen + 1) @(negedge clk);
        WEN = 1'b0;
        repeat (waitwr + 1) @(negedge clk);
        WEN = 1'b1; A = a + 8'd2; r_mst_d = d[31:16];
        repeat (waitwen + 1) @(negedge clk);
        WEN = 1'b0;
        repeat (waitwr + 1) @(negedge clk);
        WEN = 1'b1;
        @(negedge clk);
        mst_idle();
    endtask

    task automatic rd(input logic [7:0] a, input int waitrd, output logic [15:0] q);
        @(negedge clk);
        CSN = 1'b0; OEN = 1'b0; A = a; BLSN = 4'h0;
        repeat (waitrd + 1) @(negedge clk);
        q = D;
        mst_idle();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    logic [15:0] q;
    cyc_t        c;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_stb", bus.stb_o, 1'b0);
        check("rst_cyc", bus.cyc_o, 1'b0);
        check("rst_we",  bus.we_o,  1'b0);
        check("rst_adr", bus.adr_o, 7'h00);
        check("rst_dat", bus.dat_o, 16'h0000);
        check("rst_sel", bus.sel_o, 2'b00);
        check("rst_err", bus.err_o, 1'b0);
        check("rst_d_z", (D === 16'hzzzz), 1'b1);

        // Single write
        ack_mode = 0;
        mon_clr();
        wr(8'h24, 16'hA55A, 1, 2);
        repeat (8) @(negedge clk);
        c = get_cyc(0);
        check("wr_ncyc", n_cyc, 1);
        check("wr_adr",  c.adr, 7'h12);
        check("wr_dat",  c.dat, 16'hA55A);
        check("wr_sel",  c.sel, 2'b11);
        check("wr_we",   c.we,  1'b1);
        check("wr_err",  n_err, 0);

        // Double write within one CSN
        mon_clr();
        wr2(8'h10, 32'h1234_5678, 1, 2);
        repeat (8) @(negedge clk);
        check("wr2_ncyc", n_cyc, 2);
        c = get_cyc(0);
        check("wr2_adr0", c.adr, 7'h08);
        check("wr2_dat0", c.dat, 16'h5678);
        c = get_cyc(1);
        check("wr2_adr1", c.adr, 7'h09);
        check("wr2_dat1", c.dat, 16'h1234);
        check("wr2_err",  n_err, 0);

        // Single read, late ack
        ack_mode = 1;
        rd_data  = 16'hBEEF;
        mon_clr();
        rd(8'h06, 6, q);
        check("rd_data", q, 16'hBEEF);
        @(posedge clk);
        #1;
        check("rd_d_release", (D === 16'hzzzz), 1'b1);
        repeat (5) @(negedge clk);
        c = get_cyc(0);
        check("rd_ncyc", n_cyc, 1);
        check("rd_adr",  c.adr, 7'h03);
        check("rd_we",   c.we,  1'b0);
        check("rd_sel",  c.sel, 2'b11);
        check("rd_err",  n_err, 0);

        // Read timeout
        ack_mode = 2;
        mon_clr();
        rd(8'h0A, 20, q);
        repeat (5) @(negedge clk);
        check("rdto_data", q, 16'hDEAD);
        check("rdto_len",  last_len, 15);
        check("rdto_err",  n_err, 1);
        check("rdto_ncyc", n_cyc, 1);

        // Overrun: first write stalls, second queues, third is dropped
        mon_clr();
        wr(8'h40, 16'h1111, 1, 0);
        wr(8'h42, 16'h2222, 1, 0);
        wr(8'h44, 16'h3333, 1, 0);
        repeat (40) @(negedge clk);
        check("ovr_ncyc", n_cyc, 2);
        c = get_cyc(0);
        check("ovr_adr0", c.adr, 7'h20);
        check("ovr_dat0", c.dat, 16'h1111);
        c = get_cyc(1);
        check("ovr_adr1", c.adr, 7'h21);
        check("ovr_dat1", c.dat, 16'h2222);
        check("ovr_err",  n_err, 3);

        // Illegal CSN=WEN=OEN=0
        ack_mode = 0;
        mon_clr();
        @(negedge clk);
        CSN = 1'b0; WEN = 1'b0; OEN = 1'b0;
        repeat (3) @(negedge clk);
        mst_idle();
        repeat (6) @(negedge clk);
        check("ill_err",  n_err, 1);
        check("ill_ncyc", n_cyc, 0);

        // Reset in the middle of a read
        ack_mode = 2;
        @(negedge clk);
        CSN = 1'b0; OEN = 1'b0; A = 8'h30; BLSN = 4'h0;
        for (int i = 0; i < 20 && !bus.stb_o; i++) @(negedge clk);
        check("rstrd_stb_seen", bus.stb_o, 1'b1);
        rst = 1'b1;
        mst_idle();
        @(negedge clk);
        rst = 1'b0;
        check("rstrd_stb", bus.stb_o, 1'b0);
        check("rstrd_cyc", bus.cyc_o, 1'b0);
        check("rstrd_d_z", (D === 16'hzzzz), 1'b1);
        ack_mode = 0;
        mon_clr();
        wr(8'h5C, 16'hC0DE, 1, 2);
        repeat (8) @(negedge clk);
        c = get_cyc(0);
        check("rstrd_wr_ncyc", n_cyc, 1);
        check("rstrd_wr_adr",  c.adr, 7'h2E);
        check("rstrd_wr_dat",  c.dat, 16'hC0DE);
        check("rstrd_wr_err",  n_err, 0);

        check("cyc_eq_stb", n_cs_ne, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
